// File: rtl/iobus_uart_tx.sv
// IOBUS-mapped 8N1 UART transmitter: TXDATA pushes bytes into a small FIFO,
// BAUD_DIV sets cycles per bit, STATUS exposes count/overrun/empty/full/busy.
module iobus_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        TX,
    output logic        TX_IDLE
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int unsigned PW        = $clog2(FIFO_DEPTH);
    localparam logic [3:0]  DEPTH_CNT = 4'(FIFO_DEPTH);

    logic          sel_data, sel_stat, sel_div;
    logic          push_req, push_acc, pop;
    logic          full, empty, busy;

    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [3:0]    count_q, count_d;
    logic          ovr_q, ovr_d;
    logic [15:0]   div_q, div_d;

    logic [1:0]    state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;
    logic          tx_q, tx_d;

    logic          unused_wdata_hi;
    assign unused_wdata_hi = ^IOBUS_OUT[31:16];

    assign sel_data = (IOBUS_ADDR == BASE_ADDR);
    assign sel_stat = (IOBUS_ADDR == BASE_ADDR + 32'h4);
    assign sel_div  = (IOBUS_ADDR == BASE_ADDR + 32'h8);

    assign full     = (count_q == DEPTH_CNT);
    assign empty    = (count_q == 4'd0);
    assign busy     = (state_q != ST_IDLE);
    assign push_req = IOBUS_WR && sel_data;
    // A full FIFO still accepts a byte when the FSM frees a slot on the same edge.
    assign push_acc = push_req && (!full || pop);

    always_comb begin
        IOBUS_IN = '0;
        if (sel_stat) begin
            IOBUS_IN = {24'b0, count_q, ovr_q, empty, full, busy};
        end else if (sel_div) begin
            IOBUS_IN = {16'b0, div_q};
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovr_d   = ovr_q;
        div_d   = div_q;
        if (push_acc) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        case ({push_acc, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
        if (push_req && full && !pop) begin
            ovr_d = 1'b1;
        end else if (IOBUS_WR && sel_stat && IOBUS_OUT[3]) begin
            ovr_d = 1'b0;
        end
        if (IOBUS_WR && sel_div) begin
            div_d = (IOBUS_OUT[15:0] == 16'd0) ? 16'd1 : IOBUS_OUT[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_q[rptr_q];
                    cnt_d   = div_q - 16'd1;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                    cnt_d   = div_q - 16'd1;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = div_q - 16'd1;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == 16'd0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_q[rptr_q];
                        cnt_d   = div_q - 16'd1;
                        state_d = ST_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
            div_q   <= DIV_RESET;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
            div_q   <= div_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_acc) begin
            fifo_q[wptr_q] <= IOBUS_OUT[7:0];
        end
    end

    assign TX      = tx_q;
    assign TX_IDLE = empty && !busy;

endmodule

// File: tb/tb_iobus_uart_tx.sv
// Self-checking bench for iobus_uart_tx: register table, serial-stream model
// built from frame start times, reset and overrun corner cases.
module tb_iobus_uart_tx;

    localparam logic [31:0] BASE = 32'h1100_0100;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] IOBUS_ADDR = '0;
    logic [31:0] IOBUS_OUT = '0;
    logic        IOBUS_WR = 1'b0;
    logic [31:0] IOBUS_IN;
    logic        TX;
    logic        TX_IDLE;

    int n_assert = 0;
    int n_fail   = 0;

    // Stream under test: bytes, write gaps, relative write edges, divisor.
    logic [7:0] sb_byte [16];
    int         sb_gap  [16];
    int         sb_w    [16];
    int         sb_n;
    int         sb_d;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [16];

    iobus_uart_tx #(
        .BASE_ADDR (BASE),
        .FIFO_DEPTH(8),
        .DIV_RESET (16'd868)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IOBUS_ADDR(IOBUS_ADDR),
        .IOBUS_OUT (IOBUS_OUT),
        .IOBUS_WR  (IOBUS_WR),
        .IOBUS_IN  (IOBUS_IN),
        .TX        (TX),
        .TX_IDLE   (TX_IDLE)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] status_word(input int cnt, input logic ovr,
                                                input logic emp, input logic ful,
                                                input logic bsy);
        return {24'b0, 4'(cnt), ovr, emp, ful, bsy};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge CLK);
        IOBUS_ADDR = addr;
        IOBUS_OUT  = data;
        IOBUS_WR   = 1'b1;
        @(posedge CLK);
        #1;
        IOBUS_WR   = 1'b0;
        IOBUS_ADDR = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge CLK);
        IOBUS_ADDR = addr;
        IOBUS_WR   = 1'b0;
        #1;
        data = IOBUS_IN;
    endtask

    task automatic sync();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_stream();
        for (int i = 0; i < sb_n; i++) begin
            repeat (sb_gap[i]) @(posedge CLK);
            bus_write(BASE, {24'b0, sb_byte[i]});
        end
    endtask

    task automatic set_stream_times();
        for (int i = 0; i < sb_n; i++) begin
            sb_w[i] = (i == 0) ? 0 : sb_w[i-1] + 1 + sb_gap[i];
        end
    endtask

    // Each byte starts one edge after its write, or right after the previous
    // frame, whichever is later; frames span 10*div cycles.
    task automatic check_stream(input string name);
        int s [16];
        int nerr [17];
        int fj [17];
        logic fa_tx [17], fa_id [17], fe_tx [17], fe_id [17];
        int last, f, pos;
        logic etx, eidle, pend;
        logic [7:0] b;
        for (int i = 0; i < sb_n; i++) begin
            if (i == 0) s[i] = sb_w[i] + 1;
            else s[i] = (sb_w[i] + 1 > s[i-1] + 10 * sb_d) ? sb_w[i] + 1 : s[i-1] + 10 * sb_d;
        end
        last = s[sb_n-1] + 10 * sb_d;
        for (int i = 0; i <= sb_n; i++) begin
            nerr[i] = 0;
            fj[i] = 0;
            fa_tx[i] = 1'b0; fa_id[i] = 1'b0; fe_tx[i] = 1'b0; fe_id[i] = 1'b0;
        end
        @(posedge CLK);
        for (int j = 0; j <= last + 3; j++) begin
            @(negedge CLK);
            f = sb_n;
            pend = 1'b0;
            etx = 1'b1;
            eidle = 1'b1;
            for (int i = 0; i < sb_n; i++) begin
                if (j >= s[i] && j < s[i] + 10 * sb_d) f = i;
                if (sb_w[i] <= j && j < s[i]) pend = 1'b1;
            end
            if (f < sb_n) begin
                pos = (j - s[f]) / sb_d;
                b = sb_byte[f];
                eidle = 1'b0;
                if (pos == 0) etx = 1'b0;
                else if (pos == 9) etx = 1'b1;
                else etx = b[pos-1];
            end else begin
                eidle = !pend;
            end
            if (TX !== etx || TX_IDLE !== eidle) begin
                if (nerr[f] == 0) begin
                    fj[f] = j;
                    fa_tx[f] = TX; fa_id[f] = TX_IDLE;
                    fe_tx[f] = etx; fe_id[f] = eidle;
                end
                nerr[f]++;
            end
        end
        for (int i = 0; i <= sb_n; i++) begin
            n_assert++;
            if (nerr[i] != 0) begin
                n_fail++;
                $display("FAIL %s %s%0d: %0d bad cycles, first at cycle %0d TX=%b TX_IDLE=%b expected TX=%b TX_IDLE=%b",
                         name, (i == sb_n) ? "gaps" : "frame", i, nerr[i], fj[i],
                         fa_tx[i], fa_id[i], fe_tx[i], fe_id[i]);
            end
        end
    endtask

    task automatic run_single(input string name, input logic [7:0] byte_v, input int d);
        sb_n = 1;
        sb_d = d;
        sb_byte[0] = byte_v;
        sb_gap[0] = 0;
        set_stream_times();
        sync();
        fork
            drive_stream();
            check_stream(name);
        join
    endtask

    initial begin
        logic [31:0] rd;
        int bad;

        tbl[0]  = '{BASE + 32'h8,        1'b0, 32'h0,         32'd868};
        tbl[1]  = '{BASE + 32'h4,        1'b0, 32'h0,         32'h04};
        tbl[2]  = '{BASE,                1'b0, 32'h0,         32'h0};
        tbl[3]  = '{BASE + 32'hC,        1'b0, 32'h0,         32'h0};
        tbl[4]  = '{BASE + 32'h100,      1'b0, 32'h0,         32'h0};
        tbl[5]  = '{BASE ^ 32'h8000_0008, 1'b0, 32'h0,        32'h0};
        tbl[6]  = '{BASE + 32'hC,        1'b1, 32'hFFFF_FFFF, 32'h0};
        tbl[7]  = '{BASE + 32'h4,        1'b1, 32'hFFFF_FFFF, 32'h0};
        tbl[8]  = '{BASE + 32'h4,        1'b0, 32'h0,         32'h04};
        tbl[9]  = '{BASE + 32'h8,        1'b0, 32'h0,         32'd868};
        tbl[10] = '{BASE + 32'h8,        1'b1, 32'h0001_2345, 32'h0};
        tbl[11] = '{BASE + 32'h8,        1'b0, 32'h0,         32'h2345};
        tbl[12] = '{BASE + 32'h8,        1'b1, 32'h0,         32'h0};
        tbl[13] = '{BASE + 32'h8,        1'b0, 32'h0,         32'h1};
        tbl[14] = '{BASE + 32'h8,        1'b1, 32'h4,         32'h0};
        tbl[15] = '{BASE + 32'h8,        1'b0, 32'h0,         32'h4};

        repeat (3) @(posedge CLK);
        #1;
        chk("reset TX", {31'b0, TX}, 32'h1);
        chk("reset TX_IDLE", {31'b0, TX_IDLE}, 32'h1);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 16; i++) begin
            if (tbl[i].wr) begin
                bus_write(tbl[i].addr, tbl[i].data);
            end else begin
                bus_read(tbl[i].addr, rd);
                chk($sformatf("vec%0d", i), rd, tbl[i].exp);
            end
        end
        chk("TX after table", {31'b0, TX}, 32'h1);
        chk("TX_IDLE after table", {31'b0, TX_IDLE}, 32'h1);

        run_single("byte55_div4", 8'h55, 4);
        bus_read(BASE + 32'h4, rd);
        chk("status after 0x55", rd, status_word(0, 1'b0, 1'b1, 1'b0, 1'b0));

        // Ten back-to-back pushes: nine fit (one popped at once), the tenth overruns.
        sb_n = 9;
        sb_d = 4;
        for (int i = 0; i < 9; i++) begin
            sb_byte[i] = 8'(i);
            sb_gap[i] = 0;
        end
        set_stream_times();
        sync();
        fork
            begin
                for (int i = 0; i < 10; i++) bus_write(BASE, i);
                bus_read(BASE + 32'h4, rd);
                chk("status full+overrun", rd, status_word(8, 1'b1, 1'b0, 1'b1, 1'b1));
                bus_write(BASE + 32'h4, 32'hF7);
                bus_read(BASE + 32'h4, rd);
                chk("overrun kept w/o bit3", rd, status_word(8, 1'b1, 1'b0, 1'b1, 1'b1));
                bus_write(BASE + 32'h4, 32'h08);
                bus_read(BASE + 32'h4, rd);
                chk("overrun cleared", rd, status_word(8, 1'b0, 1'b0, 1'b1, 1'b1));
            end
            check_stream("burst10");
        join
        bus_read(BASE + 32'h4, rd);
        chk("status after burst", rd, status_word(0, 1'b0, 1'b1, 1'b0, 1'b0));

        bus_write(BASE + 32'h8, 32'h0);
        bus_read(BASE + 32'h8, rd);
        chk("div zero reads 1", rd, 32'h1);
        run_single("byteA5_div1", 8'hA5, 1);

        for (int it = 0; it < 6; it++) begin
            sb_d = $urandom_range(1, 3);
            bus_write(BASE + 32'h8, sb_d);
            sb_n = $urandom_range(1, 6);
            for (int i = 0; i < sb_n; i++) begin
                sb_byte[i] = 8'($urandom_range(0, 255));
                sb_gap[i] = (i == 0) ? 0 : $urandom_range(0, 12 * sb_d + 2);
            end
            set_stream_times();
            sync();
            fork
                drive_stream();
                check_stream($sformatf("rand%0d", it));
            join
            bus_read(BASE + 32'h4, rd);
            chk($sformatf("rand%0d status", it), rd, status_word(0, 1'b0, 1'b1, 1'b0, 1'b0));
        end

        // Reset while a zero data bit is on the line and two bytes are queued.
        bus_write(BASE + 32'h8, 32'h4);
        sync();
        bus_write(BASE, 32'h00);
        bus_write(BASE, 32'h11);
        bus_write(BASE, 32'h22);
        repeat (8) @(posedge CLK);
        #2;
        chk("TX low before reset", {31'b0, TX}, 32'h0);
        RST_N = 1'b0;
        #1;
        chk("TX high in reset", {31'b0, TX}, 32'h1);
        chk("TX_IDLE high in reset", {31'b0, TX_IDLE}, 32'h1);
        bus_read(BASE + 32'h8, rd);
        chk("div reset value", rd, 32'd868);
        @(negedge CLK);
        RST_N = 1'b1;
        bus_read(BASE + 32'h4, rd);
        chk("status after reset", rd, status_word(0, 1'b0, 1'b1, 1'b0, 1'b0));
        bad = 0;
        for (int j = 0; j < 60; j++) begin
            @(negedge CLK);
            if (TX !== 1'b1 || TX_IDLE !== 1'b1) bad++;
        end
        chk("line quiet after reset", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
